pkt_stream_arbiter: RTL and testbench

- Shares one 64-bit sof/eof packet stream, the input of the header-insertion stage, between NUM_SRC packet sources.
- Grants are per whole packet, round-robin, and registered; the granted source's beats are muxed to the output with one register stage.
- Enforces a programmable idle gap between packets so the downstream stage can absorb its inserted header beat.
- Sits directly upstream of the header inserter.

---
 rtl/pkt_stream_arbiter.sv | 165 ++++++++++++++++
 tb/tb_pkt_stream_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_stream_arbiter.sv
// Whole-packet round-robin arbiter that muxes NUM_SRC sof/eof sources onto one registered stream.
// Optional macro PKT_ARB_TIMEOUT_EN releases a grant whose sof never arrives within SOF_TIMEOUT cycles.
module pkt_stream_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int DW          = 64,
    parameter int GAP_CYCLES  = 2,
    parameter int SOF_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic [NUM_SRC-1:0]         src_req,
    input  logic [NUM_SRC-1:0]         src_sof,
    input  logic [NUM_SRC-1:0]         src_eof,
    input  logic [NUM_SRC*DW-1:0]      src_data,
    input  logic [NUM_SRC*2-1:0]       src_valid_cnt,
    output logic [NUM_SRC-1:0]         src_grant,
    output logic                       sof_out,
    output logic                       eof_out,
    output logic [DW-1:0]              data_out,
    output logic [1:0]                 valid_cnt_out,
    output logic [$clog2(NUM_SRC)-1:0] cur_src,
    output logic                       busy,
    output logic                       err_sof,
    output logic                       err_timeout
);

    localparam int SW = $clog2(NUM_SRC);
    localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;

    state_t          state, state_nxt, after_rel;
    logic [SW-1:0]   rr_ptr, rr_nxt, pick, cur_src_nxt, next_src;
    logic [3:0]      gap_cnt, gap_nxt;
    logic [NUM_SRC-1:0] grant_nxt;
    logic            any_req, sel_sof, sel_eof, beat_en, pkt_done, tmo_hit;
    logic [DW-1:0]   sel_data, data_nxt;
    logic [1:0]      sel_vc, vc_nxt;
    logic            sof_nxt, eof_nxt, err_sof_nxt;
    int              pick_idx;

    assign sel_sof  = src_sof[cur_src];
    assign sel_eof  = src_eof[cur_src];
    assign sel_data = src_data[int'(cur_src)*DW +: DW];
    assign sel_vc   = src_valid_cnt[int'(cur_src)*2 +: 2];
    assign any_req  = |src_req;
    assign busy     = (state == GRANT) || (state == XFER);
    assign next_src = (int'(cur_src) == NUM_SRC - 1) ? '0 : cur_src + 1'b1;
    assign after_rel = (GAP_CYCLES == 0) ? IDLE : GAP;

    // Scan downward so the requester closest above rr_ptr is the last (winning) assignment.
    always_comb begin
        pick     = '0;
        pick_idx = 0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            pick_idx = int'(rr_ptr) + i;
            if (pick_idx >= NUM_SRC) pick_idx = pick_idx - NUM_SRC;
            if (src_req[pick_idx]) pick = SW'(pick_idx);
        end
    end

    assign beat_en  = ((state == GRANT) && sel_sof) || (state == XFER);
    assign pkt_done = ((state == GRANT) && sel_sof && sel_eof) ||
                      ((state == XFER) && sel_eof) || tmo_hit;

`ifdef PKT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(SOF_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == GRANT) && !sel_sof && (tmo_cnt == TW'(SOF_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            tmo_cnt     <= (state == GRANT) ? tmo_cnt + 1'b1 : '0;
            err_timeout <= tmo_hit;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   if (pkt_done) state_nxt = after_rel;
                     else if (sel_sof) state_nxt = XFER;
            XFER:    if (pkt_done) state_nxt = after_rel;
            GAP:     if (gap_cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A repeated sof inside XFER is flagged and suppressed, but its beat still goes out.
    always_comb begin
        grant_nxt   = '0;
        cur_src_nxt = cur_src;
        rr_nxt      = rr_ptr;
        gap_nxt     = gap_cnt;
        sof_nxt     = 1'b0;
        eof_nxt     = 1'b0;
        data_nxt    = '0;
        vc_nxt      = '0;
        err_sof_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt[pick] = 1'b1;
                    cur_src_nxt     = pick;
                end
            end
            GRANT, XFER: begin
                grant_nxt = src_grant;
                if (beat_en) begin
                    sof_nxt     = (state == GRANT);
                    eof_nxt     = sel_eof;
                    data_nxt    = sel_data;
                    vc_nxt      = sel_vc;
                    err_sof_nxt = (state == XFER) && sel_sof;
                end
                if (pkt_done) begin
                    grant_nxt = '0;
                    rr_nxt    = next_src;
                    gap_nxt   = GAP_LOAD;
                end
            end
            GAP:     gap_nxt = gap_cnt - 1'b1;
            default: grant_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            src_grant     <= '0;
            cur_src       <= '0;
            rr_ptr        <= '0;
            gap_cnt       <= '0;
            sof_out       <= 1'b0;
            eof_out       <= 1'b0;
            data_out      <= '0;
            valid_cnt_out <= '0;
            err_sof       <= 1'b0;
        end else begin
            src_grant     <= grant_nxt;
            cur_src       <= cur_src_nxt;
            rr_ptr        <= rr_nxt;
            gap_cnt       <= gap_nxt;
            sof_out       <= sof_nxt;
            eof_out       <= eof_nxt;
            data_out      <= data_nxt;
            valid_cnt_out <= vc_nxt;
            err_sof       <= err_sof_nxt;
        end
    end

endmodule

// File: tb/tb_pkt_stream_arbiter.sv
// Randomized bench for pkt_stream_arbiter against a packet-level reference model.
// Also exercises reset during a transfer and a grant whose sof never comes (PKT_ARB_TIMEOUT_EN aware).
module tb_pkt_stream_arbiter;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int GAP = 2;
    localparam int TMO = 16;

    logic              clk;
    logic              rstb;
    logic [N-1:0]      src_req, src_sof, src_eof;
    logic [N*DW-1:0]   src_data;
    logic [N*2-1:0]    src_valid_cnt;
    logic [N-1:0]      src_grant;
    logic              sof_out, eof_out;
    logic [DW-1:0]     data_out;
    logic [1:0]        valid_cnt_out;
    logic [1:0]        cur_src;
    logic              busy, err_sof, err_timeout;

    pkt_stream_arbiter #(
        .NUM_SRC(N), .DW(DW), .GAP_CYCLES(GAP), .SOF_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rstb(rstb),
        .src_req(src_req), .src_sof(src_sof), .src_eof(src_eof),
        .src_data(src_data), .src_valid_cnt(src_valid_cnt),
        .src_grant(src_grant), .sof_out(sof_out), .eof_out(eof_out),
        .data_out(data_out), .valid_cnt_out(valid_cnt_out),
        .cur_src(cur_src), .busy(busy), .err_sof(err_sof), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    // Reference model: phase 0 = no owner, 1 = granted awaiting sof, 2 = inside packet
    int          m_phase, m_owner, m_rr, m_idle_from, m_wait;
    logic [N-1:0] m_grant;
    logic         e_sof, e_eof, e_errsof, e_errtmo;
    logic [DW-1:0] e_data;
    logic [1:0]   e_vc;

    logic [N-1:0]  a_req, a_sof, a_eof;
    logic [DW-1:0] a_data [N];
    logic [1:0]    a_vc [N];

    int   d_wait, d_len, d_left, min_len;
    bit   quiet, use_force, no_sof_mode;
    logic [N-1:0] force_req;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_rr = 0; m_wait = 0;
        m_grant = '0; m_idle_from = cyc;
        e_sof = 0; e_eof = 0; e_errsof = 0; e_errtmo = 0; e_data = '0; e_vc = '0;
    endtask

    task automatic model_release();
        m_grant = '0;
        m_rr = (m_owner + 1) % N;
        m_phase = 0;
        m_idle_from = cyc + GAP;
    endtask

    task automatic model_update();
        int k;
        bit found;
        e_sof = 0; e_eof = 0; e_errsof = 0; e_errtmo = 0; e_data = '0; e_vc = '0;
        k = m_owner;
        case (m_phase)
            0: begin
                if ((cyc - 1) >= m_idle_from && a_req != '0) begin
                    found = 0;
                    for (int i = 0; i < N; i++) begin
                        if (!found && a_req[(m_rr + i) % N]) begin
                            found = 1;
                            k = (m_rr + i) % N;
                        end
                    end
                    m_owner = k;
                    m_grant = '0;
                    m_grant[k] = 1'b1;
                    m_phase = 1;
                    m_wait = 0;
                    d_wait = $urandom_range(0, 3);
                    d_len  = $urandom_range(min_len, 4);
                end
            end
            1: begin
                if (a_sof[k]) begin
                    e_sof = 1; e_eof = a_eof[k]; e_data = a_data[k]; e_vc = a_vc[k];
                    if (a_eof[k]) model_release();
                    else m_phase = 2;
                end else begin
`ifdef PKT_ARB_TIMEOUT_EN
                    if (m_wait == TMO - 1) begin
                        e_errtmo = 1;
                        model_release();
                    end
`endif
                    m_wait++;
                end
            end
            default: begin
                e_errsof = a_sof[k]; e_eof = a_eof[k]; e_data = a_data[k]; e_vc = a_vc[k];
                if (a_eof[k]) model_release();
            end
        endcase
    endtask

    task automatic applyStimulus();
        for (int s = 0; s < N; s++) begin
            a_req[s]  = use_force ? force_req[s] : ($urandom_range(0, 99) < 35);
            a_data[s] = {$urandom, $urandom};
            a_vc[s]   = 2'($urandom_range(0, 3));
            a_sof[s]  = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
            a_eof[s]  = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
        end
        if (m_phase == 1) begin
            if (no_sof_mode || d_wait > 0) begin
                a_sof[m_owner] = 0; a_eof[m_owner] = 0;
                if (d_wait > 0) d_wait--;
            end else begin
                a_sof[m_owner] = 1;
                a_eof[m_owner] = (d_len == 1);
                d_left = d_len - 1;
            end
        end else if (m_phase == 2) begin
            a_sof[m_owner] = ($urandom_range(0, 5) == 0);
            a_eof[m_owner] = (d_left == 1);
            d_left--;
        end
        src_req = a_req; src_sof = a_sof; src_eof = a_eof;
        for (int s = 0; s < N; s++) begin
            src_data[s*DW +: DW]    = a_data[s];
            src_valid_cnt[s*2 +: 2] = a_vc[s];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        model_update();
        checkOutput("grant",     src_grant,     m_grant);
        checkOutput("cur_src",   cur_src,       m_owner);
        checkOutput("busy",      busy,          m_phase != 0);
        checkOutput("sof_out",   sof_out,       e_sof);
        checkOutput("eof_out",   eof_out,       e_eof);
        checkOutput("data_out",  data_out,      e_data);
        checkOutput("valid_cnt", valid_cnt_out, e_vc);
        checkOutput("err_sof",   err_sof,       e_errsof);
        checkOutput("err_tmo",   err_timeout,   e_errtmo);
        applyStimulus();
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_grant"}, src_grant, 0);
        checkOutput({tag, "_sof"},   sof_out, 0);
        checkOutput({tag, "_eof"},   eof_out, 0);
        checkOutput({tag, "_data"},  data_out, 0);
        checkOutput({tag, "_vc"},    valid_cnt_out, 0);
        checkOutput({tag, "_cur"},   cur_src, 0);
        checkOutput({tag, "_busy"},  busy, 0);
        checkOutput({tag, "_esof"},  err_sof, 0);
        checkOutput({tag, "_etmo"},  err_timeout, 0);
    endtask

    initial begin
        clk = 0; rstb = 0; cyc = 0;
        quiet = 0; use_force = 0; no_sof_mode = 0; force_req = '0; min_len = 1;
        d_wait = 0; d_len = 1; d_left = 0;
        src_req = '0; src_sof = '0; src_eof = '0; src_data = '0; src_valid_cnt = '0;
        a_req = '0; a_sof = '0; a_eof = '0;
        for (int s = 0; s < N; s++) begin a_data[s] = '0; a_vc[s] = '0; end

        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        model_reset();
        applyStimulus();
        rstb = 1;

        for (int i = 0; i < 1500; i++) step();

        // Drive source 0 into the middle of a long packet, then reset asynchronously.
        quiet = 1; use_force = 1; force_req = 4'b0001; min_len = 3;
        for (int i = 0; i < 200 && m_phase != 2; i++) step();
        checkOutput("reach_xfer", m_phase, 2);
        #3;
        rstb = 0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #2;
        force_req = 4'b1000; min_len = 1;
        model_reset();
        applyStimulus();
        rstb = 1;
        step();
        checkOutput("rst_grant3", src_grant, 4'b1000);

        // Owner never raises sof: grant is held, or released by the timeout when enabled.
        no_sof_mode = 1; force_req = 4'b1001;
        for (int i = 0; i < 120; i++) step();
`ifndef PKT_ARB_TIMEOUT_EN
        checkOutput("hold_grant", src_grant, 4'b1000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
